// File: rtl/regbank_pkg.sv
// Shared constants and FSM state encoding for the register-bank access controller.
package regbank_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/decoder3to8.sv
// Index-to-one-hot decoder with enable; all zeros when disabled.
module decoder3to8 #(
    parameter int ADDR_W   = regbank_pkg::ADDR_W,
    parameter int NUM_REGS = regbank_pkg::NUM_REGS
) (
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] dec_o
);

    always_comb begin
        // NOTE: assigning a default before any conditional keeps this purely combinational (no latch).
        dec_o = '0;
        if (en_i) begin
            dec_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/regbank_ctrl.sv
// Two-requester round-robin arbiter driving a register bank through IDLE/ACCESS/RESP.
module regbank_ctrl #(
    parameter int DATA_W   = regbank_pkg::DATA_W,
    parameter int ADDR_W   = regbank_pkg::ADDR_W,
    parameter int NUM_REGS = regbank_pkg::NUM_REGS
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req0_i,
    input  logic                req1_i,
    input  logic                wr0_i,
    input  logic                wr1_i,
    input  logic [ADDR_W-1:0]   addr0_i,
    input  logic [ADDR_W-1:0]   addr1_i,
    input  logic [DATA_W-1:0]   wdata0_i,
    input  logic [DATA_W-1:0]   wdata1_i,
    output logic                ack0_o,
    output logic                ack1_o,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic                busy_o,
    output logic [NUM_REGS-1:0] bank_enable_o,
    output logic [ADDR_W-1:0]   bank_reg_num_o,
    output logic [DATA_W-1:0]   bank_in_o,
    input  logic [DATA_W-1:0]   bank_out_i
);

    import regbank_pkg::*;

    state_e              state_q;
    logic                winner_q;
    logic                winner_d;
    logic                last_grant_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                ack0_q;
    logic                ack1_q;

    // On a tie the requester not granted last time wins; otherwise whoever is asking.
    always_comb begin
        winner_d = req1_i;
        if (req0_i && req1_i) begin
            winner_d = ~last_grant_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            winner_q     <= 1'b0;
            last_grant_q <= 1'b1;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_data_q    <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req0_i || req1_i) begin
                        state_q  <= ST_ACCESS;
                        winner_q <= winner_d;
                        wr_q     <= winner_d ? wr1_i    : wr0_i;
                        addr_q   <= winner_d ? addr1_i  : addr0_i;
                        wdata_q  <= winner_d ? wdata1_i : wdata0_i;
                    end
                end
                ST_ACCESS: begin
                    state_q      <= ST_RESP;
                    rd_data_q    <= bank_out_i;
                    ack0_q       <= ~winner_q;
                    ack1_q       <= winner_q;
                    last_grant_q <= winner_q;
                end
                ST_RESP: begin
                    // Return the bank-facing registers to their idle values.
                    state_q <= ST_IDLE;
                    wr_q    <= 1'b0;
                    addr_q  <= '0;
                    wdata_q <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    decoder3to8 #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_decoder (
        .addr_i (addr_q),
        .en_i   ((state_q == ST_ACCESS) && wr_q),
        .dec_o  (bank_enable_o)
    );

    assign busy_o         = (state_q != ST_IDLE);
    assign bank_reg_num_o = addr_q;
    assign bank_in_o      = wdata_q;
    assign rd_data_o      = rd_data_q;
    assign ack0_o         = ack0_q;
    assign ack1_o         = ack1_q;

endmodule

// File: tb/tb_regbank_ctrl.sv
// Directed self-checking bench for regbank_ctrl with a behavioural 8x16 register bank.
module tb_regbank_ctrl;

    logic        clk;
    logic        rst;
    logic        req0, req1, wr0, wr1;
    logic [2:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1, busy;
    logic [15:0] rd_data, bank_in, bank_out;
    logic [7:0]  bank_enable;
    logic [2:0]  bank_reg_num;

    logic [15:0] regs [8] = '{default: 16'h0000};

    int tests_run    = 0;
    int tests_failed = 0;

    regbank_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req0_i         (req0),
        .req1_i         (req1),
        .wr0_i          (wr0),
        .wr1_i          (wr1),
        .addr0_i        (addr0),
        .addr1_i        (addr1),
        .wdata0_i       (wdata0),
        .wdata1_i       (wdata1),
        .ack0_o         (ack0),
        .ack1_o         (ack1),
        .rd_data_o      (rd_data),
        .busy_o         (busy),
        .bank_enable_o  (bank_enable),
        .bank_reg_num_o (bank_reg_num),
        .bank_in_o      (bank_in),
        .bank_out_i     (bank_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (bank_enable[i]) regs[i] <= bank_in;
        end
    end
    assign bank_out = regs[bank_reg_num];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if ({ack0, ack1, busy} !== 3'b000) begin
            $display("FAIL reset_ctrl: ack0/ack1/busy got %b exp 000", {ack0, ack1, busy});
            tests_failed++;
        end
        tests_run++;
        if (rd_data !== 16'h0000 || bank_in !== 16'h0000) begin
            $display("FAIL reset_data: rd_data %h bank_in %h exp 0000 0000", rd_data, bank_in);
            tests_failed++;
        end
        tests_run++;
        if (bank_enable !== 8'h00 || bank_reg_num !== 3'd0) begin
            $display("FAIL reset_bank: enable %b reg_num %0d exp 00000000 0", bank_enable, bank_reg_num);
            tests_failed++;
        end
        tick();
        tick();
        tests_run++;
        if (busy !== 1'b0 || bank_enable !== 8'h00) begin
            $display("FAIL idle_stay: busy %b enable %b exp 0 00000000", busy, bank_enable);
            tests_failed++;
        end
    endtask

    task automatic test_write();
        logic [2:0]  a_tab [2] = '{3'd0, 3'd7};
        logic [15:0] d_tab [2] = '{16'd256, 16'h7777};
        for (int k = 0; k < 2; k++) begin
            logic [7:0] exp_en;
            exp_en = 8'b1 << a_tab[k];
            req0 = 1'b1; wr0 = 1'b1; addr0 = a_tab[k]; wdata0 = d_tab[k];
            #1;
            tests_run++;
            if (bank_enable !== 8'h00 || busy !== 1'b0) begin
                $display("FAIL write_idle_path: enable %b busy %b exp 00000000 0", bank_enable, busy);
                tests_failed++;
            end
            tick();
            tests_run++;
            if (bank_enable !== exp_en || bank_in !== d_tab[k] || bank_reg_num !== a_tab[k] || ack0 !== 1'b0) begin
                $display("FAIL write_access: enable %b in %h num %0d ack0 %b exp %b %h %0d 0",
                         bank_enable, bank_in, bank_reg_num, ack0, exp_en, d_tab[k], a_tab[k]);
                tests_failed++;
            end
            tick();
            tests_run++;
            if (ack0 !== 1'b1 || ack1 !== 1'b0 || bank_enable !== 8'h00) begin
                $display("FAIL write_ack: ack0 %b ack1 %b enable %b exp 1 0 00000000", ack0, ack1, bank_enable);
                tests_failed++;
            end
            req0 = 1'b0;
            tick();
            tests_run++;
            if (ack0 !== 1'b0 || busy !== 1'b0 || regs[a_tab[k]] !== d_tab[k]) begin
                $display("FAIL write_done: ack0 %b busy %b reg %h exp 0 0 %h", ack0, busy, regs[a_tab[k]], d_tab[k]);
                tests_failed++;
            end
        end
    endtask

    task automatic test_tie();
        apply_reset();
        req0 = 1'b1; wr0 = 1'b1; addr0 = 3'd4; wdata0 = 16'd35;
        req1 = 1'b1; wr1 = 1'b1; addr1 = 3'd5; wdata1 = 16'd22;
        tick();
        tests_run++;
        if (bank_enable !== 8'b0001_0000) begin
            $display("FAIL tie_first_en: got %b exp 00010000", bank_enable);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
            $display("FAIL tie_first_ack: ack0 %b ack1 %b exp 1 0", ack0, ack1);
            tests_failed++;
        end
        req0 = 1'b0;
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            $display("FAIL tie_gap_idle: busy %b exp 0", busy);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (bank_enable !== 8'b0010_0000) begin
            $display("FAIL tie_second_en: got %b exp 00100000", bank_enable);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (ack1 !== 1'b1 || ack0 !== 1'b0) begin
            $display("FAIL tie_second_ack: ack1 %b ack0 %b exp 1 0", ack1, ack0);
            tests_failed++;
        end
        req1 = 1'b0;
        tick();
        tests_run++;
        if (regs[4] !== 16'd35 || regs[5] !== 16'd22) begin
            $display("FAIL tie_contents: reg4 %0d reg5 %0d exp 35 22", regs[4], regs[5]);
            tests_failed++;
        end
    endtask

    task automatic test_read();
        req1 = 1'b1; wr1 = 1'b0; addr1 = 3'd4; wdata1 = 16'hFFFF;
        tick();
        tests_run++;
        if (bank_enable !== 8'h00 || bank_reg_num !== 3'd4) begin
            $display("FAIL read_access: enable %b num %0d exp 00000000 4", bank_enable, bank_reg_num);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (ack1 !== 1'b1 || ack0 !== 1'b0 || rd_data !== 16'd35 || bank_enable !== 8'h00) begin
            $display("FAIL read_ack: ack1 %b ack0 %b rd_data %0d enable %b exp 1 0 35 00000000",
                     ack1, ack0, rd_data, bank_enable);
            tests_failed++;
        end
        req1 = 1'b0;
        tick();
        tests_run++;
        if (ack1 !== 1'b0 || rd_data !== 16'd35 || regs[4] !== 16'd35) begin
            $display("FAIL read_hold: ack1 %b rd_data %0d reg4 %0d exp 0 35 35", ack1, rd_data, regs[4]);
            tests_failed++;
        end
    endtask

    task automatic test_round_robin();
        logic        exp_id;
        logic [15:0] exp_rd;
        int          waited;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 3'd4;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 3'd5;
        for (int k = 0; k < 4; k++) begin
            exp_id = k[0];
            exp_rd = exp_id ? 16'd22 : 16'd35;
            waited = 0;
            tick();
            while (!(ack0 || ack1) && waited < 6) begin
                tick();
                waited++;
            end
            tests_run++;
            if (!(ack0 || ack1)) begin
                $display("FAIL rr_timeout: no ack for grant %0d within 6 cycles", k);
                tests_failed++;
            end else if ((ack0 && ack1) || ack1 !== exp_id || rd_data !== exp_rd) begin
                $display("FAIL rr_grant: grant %0d ack0 %b ack1 %b rd_data %0d exp ack1=%b rd_data %0d",
                         k, ack0, ack1, rd_data, exp_id, exp_rd);
                tests_failed++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_input_change();
        req0 = 1'b1; wr0 = 1'b1; addr0 = 3'd3; wdata0 = 16'h1234;
        tick();
        addr0 = 3'd6; wdata0 = 16'hDEAD;
        #1;
        tests_run++;
        if (bank_enable !== 8'b0000_1000 || bank_in !== 16'h1234) begin
            $display("FAIL chg_access: enable %b in %h exp 00001000 1234", bank_enable, bank_in);
            tests_failed++;
        end
        tick();
        req0 = 1'b0;
        tick();
        tests_run++;
        if (regs[3] !== 16'h1234 || regs[6] !== 16'h0000) begin
            $display("FAIL chg_contents: reg3 %h reg6 %h exp 1234 0000", regs[3], regs[6]);
            tests_failed++;
        end
    endtask

    task automatic test_reset_mid_op();
        int seen_ack;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 3'd2; wdata0 = 16'hBEEF;
        tick();
        tests_run++;
        if (bank_enable !== 8'b0000_0100) begin
            $display("FAIL rst_pre_en: got %b exp 00000100", bank_enable);
            tests_failed++;
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (bank_enable !== 8'h00 || busy !== 1'b0 || ack0 !== 1'b0) begin
            $display("FAIL rst_async: enable %b busy %b ack0 %b exp 00000000 0 0", bank_enable, busy, ack0);
            tests_failed++;
        end
        req0 = 1'b0;
        tick();
        rst = 1'b0;
        seen_ack = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ack0 || ack1) seen_ack++;
        end
        tests_run++;
        if (seen_ack !== 0 || regs[2] !== 16'h0000 || rd_data !== 16'h0000) begin
            $display("FAIL rst_dropped: acks %0d reg2 %h rd_data %h exp 0 0000 0000", seen_ack, regs[2], rd_data);
            tests_failed++;
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_tie();
        test_read();
        test_round_robin();
        test_input_change();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regbank_ctrl.md
REGBANK_CTRL -- requirements
Module: regbank_ctrl

Interface
REQ-001 Parameter: DATA_W, 16, register data width.
REQ-002 Parameter: ADDR_W, 3, register index width.
REQ-003 Parameter: NUM_REGS, 8, register count, SHALL equal 2**ADDR_W.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req0, req1  input  1 each  access request, level, held by requester until its ack.
REQ-007 wr0, wr1  input  1 each  1 = write, 0 = read.
REQ-008 addr0, addr1  input  ADDR_W each  target register index.
REQ-009 wdata0, wdata1  input  DATA_W each  write data.
REQ-010 ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-011 rd_data  output  DATA_W  read result, valid while an ack is high.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 bank_enable  output  NUM_REGS  one-hot write-enable vector to the register bank.
REQ-014 bank_reg_num  output  ADDR_W  register index to the register bank.
REQ-015 bank_in  output  DATA_W  write data to the register bank.
REQ-016 bank_out  input  DATA_W  bank output: register bank_reg_num, combinational.

Function
REQ-017 FSM states IDLE, ACCESS, RESP; transitions IDLE->ACCESS (any req), ACCESS->RESP (always), RESP->IDLE (always).
REQ-018 In IDLE with neither req high: stay in IDLE; all outputs at their reset values.
REQ-019 In IDLE with exactly one req high: that requester wins.
REQ-020 In IDLE with both req high: the requester not granted most recently wins (round-robin).
REQ-021 On IDLE->ACCESS: latch winner id, wr, addr, wdata; later changes to requester inputs are ignored until the next IDLE.
REQ-022 In ACCESS: bank_reg_num = latched addr; bank_in = latched wdata; bank_enable = one-hot(addr) if wr, else all zeros.
REQ-023 bank_enable SHALL be nonzero only in ACCESS, and only for writes, with exactly one bit set.
REQ-024 At the end of ACCESS: capture bank_out into rd_data register (reads and writes).
REQ-025 In RESP: ack of the winner high for exactly one cycle; other ack low; rd_data holds the captured value; last-grant pointer updated to the winner.
REQ-026 Latency: req sampled in cycle N, bank write at the end of N+1, ack in N+2; throughput one transaction per 3 cycles.
REQ-027 Requester clears req at the edge ending its ack cycle; IDLE in cycle N+3 then serves the other pending requester without bias.
REQ-028 rd_data outside RESP holds its last captured value; consumers use it only with ack.
REQ-029 ack0 and ack1 SHALL never be high in the same cycle.
REQ-030 Index wrap: addr 7 maps to bank_enable bit 7; no other index arithmetic.

Reset
REQ-031 Reset asserted at any time, including mid-ACCESS: state -> IDLE asynchronously; bank_enable = 0 immediately, with no partial write committed after reset assertion.
REQ-032 Reset values: ack0 = ack1 = 0, busy = 0, rd_data = 0, bank_reg_num = 0, bank_in = 0, bank_enable = 0.
REQ-033 Last-grant pointer resets to requester 1, so requester 0 wins the first tie.
REQ-034 Transactions in flight at reset are dropped without ack; requesters re-issue.

Structure
REQ-035 Shared package regbank_pkg: DATA_W, ADDR_W, NUM_REGS constants and the FSM state encoding.
REQ-036 Sub-module decoder3to8: ADDR_W-to-NUM_REGS one-hot decoder with enable input, driving bank_enable.
REQ-037 All outputs SHALL be registered or decoded from registered state only; no combinational path from req inputs to bank_* outputs.

Verification
REQ-038 Write: req0=1, wr0=1, addr0=0, wdata0=256 -> ACCESS cycle bank_enable=8'b00000001, bank_in=256; ack0 two cycles after req; bank reg0 = 256.
REQ-039 Tie: req0 (write reg4 = 35) and req1 (write reg5 = 22) asserted in the same cycle after reset -> req0 served first (bank_enable=8'b00010000), then req1 (8'b00100000); acks 3 cycles apart.
REQ-040 Read: bank reg4 = 35; req1=1, wr1=0, addr1=4 -> bank_enable=0 throughout; ack1 with rd_data=35.
REQ-041 Round-robin: req0 and req1 both held continuously -> acks alternate 0,1,0,1; no requester granted twice in a row.
REQ-042 Reset mid-op: reset asserted during ACCESS of write reg2 = 0xBEEF -> bank_enable drops to 0 that cycle, no ack0, reg2 unchanged, busy = 0.
REQ-043 Input change: addr0 changed from 3 to 6 during ACCESS -> write still targets reg3 (bank_enable=8'b00001000).
